// File: rtl/mem_copy_pkg.sv
// Shared types and constants for the byte-wise memory copy engine.
package mem_copy_pkg;

    localparam int DEFAULT_ADDR_W = 6;
    localparam int DEFAULT_LEN_W  = 7;
    localparam int DATA_W         = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_FINISH
    } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Byte-at-a-time block copy initiator driving a single-port memory.
// Define MEMCPY_FILL_EN to add a fill mode that writes a constant without reading.
module mem_copy_engine
    import mem_copy_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        src,
    input  logic [7:0]        dst,
    input  logic [LEN_W-1:0]  len,
`ifdef MEMCPY_FILL_EN
    input  logic              fill_en,
    input  logic [DATA_W-1:0] fill_val,
`endif
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  bytes_done,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(2 ** ADDR_W);
    localparam logic [7:0]       ADDR_MASK = 8'((2 ** ADDR_W) - 1);

    state_e              state_q, state_d;
    logic [7:0]          src_q, src_d;
    logic [7:0]          dst_q, dst_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [LEN_W-1:0]    bytes_done_q, bytes_done_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [LEN_W-1:0]    idx_next;
    logic [7:0]          rd_addr;
    logic [7:0]          wr_addr;
    logic                fill_mode;
    logic [DATA_W-1:0]   write_data;

`ifdef MEMCPY_FILL_EN
    logic                fill_en_q, fill_en_d;
    logic [DATA_W-1:0]   fill_val_q, fill_val_d;

    assign fill_mode  = fill_en_q;
    assign write_data = fill_en_q ? fill_val_q : buf_q;
`else
    assign fill_mode  = 1'b0;
    assign write_data = buf_q;
`endif

    // Masking keeps the region wrapping inside the implemented address space.
    assign idx_next = idx_q + LEN_W'(1);
    assign rd_addr  = (src_q + 8'(idx_q)) & ADDR_MASK;
    assign wr_addr  = (dst_q + 8'(idx_q)) & ADDR_MASK;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        idx_d        = idx_q;
        bytes_done_d = bytes_done_q;
        buf_d        = buf_q;
`ifdef MEMCPY_FILL_EN
        fill_en_d    = fill_en_q;
        fill_val_d   = fill_val_q;
`endif
        busy         = 1'b0;
        done         = 1'b0;
        mem_addr     = 8'h00;
        mem_wdata    = '0;
        mem_write    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d        = src;
                    dst_d        = dst;
                    len_d        = (len > MAX_LEN) ? MAX_LEN : len;
                    idx_d        = '0;
                    bytes_done_d = '0;
`ifdef MEMCPY_FILL_EN
                    fill_en_d    = fill_en;
                    fill_val_d   = fill_val;
                    if (len == '0) begin
                        state_d = S_FINISH;
                    end else if (fill_en) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
`else
                    state_d = (len == '0) ? S_FINISH : S_READ;
`endif
                end
            end

            S_READ: begin
                busy     = 1'b1;
                mem_addr = rd_addr;
                buf_d    = mem_rdata;
                state_d  = S_WRITE;
            end

            S_WRITE: begin
                busy         = 1'b1;
                mem_addr     = wr_addr;
                mem_wdata    = write_data;
                mem_write    = 1'b1;
                idx_d        = idx_next;
                bytes_done_d = bytes_done_q + LEN_W'(1);
                if (idx_next == len_q) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = fill_mode ? S_WRITE : S_READ;
                end
            end

            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            bytes_done_q <= '0;
            buf_q        <= '0;
`ifdef MEMCPY_FILL_EN
            fill_en_q    <= 1'b0;
            fill_val_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            bytes_done_q <= bytes_done_d;
            buf_q        <= buf_d;
`ifdef MEMCPY_FILL_EN
            fill_en_q    <= fill_en_d;
            fill_val_q   <= fill_val_d;
`endif
        end
    end

    assign bytes_done = bytes_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural 64-byte memory.
// Fill-mode checks are included when MEMCPY_FILL_EN is defined.
module tb_mem_copy_engine;

    localparam int LEN_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [7:0]       src = 8'h00;
    logic [7:0]       dst = 8'h00;
    logic [LEN_W-1:0] len = '0;
`ifdef MEMCPY_FILL_EN
    logic             fill_en = 1'b0;
    logic [7:0]       fill_val = 8'h00;
`endif
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] bytes_done;
    logic [7:0]       mem_addr;
    logic [7:0]       mem_wdata;
    logic             mem_write;
    logic [7:0]       mem_rdata;

    logic [7:0] mem [64];

    int checkCount = 0;
    int errorCount = 0;
    int writeCount = 0;
    int doneCount = 0;
    int addrHiCount = 0;

    logic       firstBusy, firstWrite, secondWrite, doneBusy;
    logic [7:0] firstAddr, secondAddr, secondWdata;

    mem_copy_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
`ifdef MEMCPY_FILL_EN
        .fill_en    (fill_en),
        .fill_val   (fill_val),
`endif
        .busy       (busy),
        .done       (done),
        .bytes_done (bytes_done),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Combinational read, write on the rising edge, like the real data memory.
    assign mem_rdata = mem[mem_addr[5:0]];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    end

    always @(negedge clk) begin
        if (mem_write) writeCount++;
        if (done) doneCount++;
        if (mem_addr[7:6] != 2'b00) addrHiCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic preload(input int addr, input logic [7:0] value);
        mem[addr] <= value;
    endtask

    // Drives a start pulse so that it is sampled at exactly one rising edge (edge k).
    task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [LEN_W-1:0] l);
        @(negedge clk);
        src   = s;
        dst   = d;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns m where done is seen in cycle k+m; 0 means no done within the budget.
    task automatic waitDone(output int cycles);
        cycles = 0;
        for (int m = 1; m <= 300; m++) begin
            @(negedge clk);
            if (m == 1) begin
                firstBusy  = busy;
                firstAddr  = mem_addr;
                firstWrite = mem_write;
            end
            if (m == 2) begin
                secondAddr  = mem_addr;
                secondWrite = mem_write;
                secondWdata = mem_wdata;
            end
            if (done) begin
                cycles   = m;
                doneBusy = busy;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int wBefore;
        int dBefore;

        for (int i = 0; i < 64; i++) mem[i] <= 8'h00;

        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_bytes_done", bytes_done, 0);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic copy of four bytes.
        preload(0, 8'h11); preload(1, 8'h22); preload(2, 8'h33); preload(3, 8'h44);
        wBefore = writeCount;
        applyStimulus(8'd0, 8'd16, 7'd4);
        waitDone(cyc);
        checkOutput("basic_cycles", cyc, 9);
        checkOutput("basic_read_busy", firstBusy, 1);
        checkOutput("basic_read_addr", firstAddr, 0);
        checkOutput("basic_read_write", firstWrite, 0);
        checkOutput("basic_write_addr", secondAddr, 16);
        checkOutput("basic_write_en", secondWrite, 1);
        checkOutput("basic_write_data", secondWdata, 8'h11);
        checkOutput("basic_done_busy", doneBusy, 0);
        checkOutput("basic_bytes_done", bytes_done, 4);
        checkOutput("basic_writes", writeCount - wBefore, 4);
        checkOutput("basic_mem16", mem[16], 8'h11);
        checkOutput("basic_mem17", mem[17], 8'h22);
        checkOutput("basic_mem18", mem[18], 8'h33);
        checkOutput("basic_mem19", mem[19], 8'h44);
        checkOutput("basic_src0", mem[0], 8'h11);
        checkOutput("basic_src3", mem[3], 8'h44);

        // Start held through the done cycle is ignored, then accepted one cycle later.
        src   = 8'd0;
        dst   = 8'd20;
        len   = 7'd2;
        start = 1'b1;
        @(negedge clk);
        checkOutput("b2b_ignored_busy", busy, 0);
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(cyc);
        checkOutput("b2b_cycles", cyc, 5);
        checkOutput("b2b_mem20", mem[20], 8'h11);
        checkOutput("b2b_mem21", mem[21], 8'h22);

        // Start while busy is ignored; operands are latched at acceptance.
        preload(40, 8'hEE);
        applyStimulus(8'd0, 8'd24, 7'd4);
        dBefore = doneCount;
        @(negedge clk);
        @(negedge clk);
        src   = 8'd3;
        dst   = 8'd40;
        len   = 7'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(cyc);
        checkOutput("busy_start_cycles", cyc, 6);
        repeat (4) @(negedge clk);
        checkOutput("busy_start_idle", busy, 0);
        checkOutput("busy_start_dones", doneCount - dBefore, 1);
        checkOutput("busy_start_mem40", mem[40], 8'hEE);
        checkOutput("busy_start_mem24", mem[24], 8'h11);
        checkOutput("busy_start_mem27", mem[27], 8'h44);

        // Asynchronous reset during the third WRITE.
        for (int i = 16; i < 20; i++) preload(i, 8'h00);
        applyStimulus(8'd0, 8'd16, 7'd4);
        dBefore = doneCount;
        repeat (6) @(negedge clk);
        checkOutput("midrst_pre_write", mem_write, 1);
        checkOutput("midrst_pre_addr", mem_addr, 18);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_write_drop", mem_write, 0);
        checkOutput("midrst_busy_drop", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_bytes_done", bytes_done, 0);
        checkOutput("midrst_mem_addr", mem_addr, 0);
        checkOutput("midrst_mem_wdata", mem_wdata, 0);
        checkOutput("midrst_no_done", doneCount - dBefore, 0);
        checkOutput("midrst_mem17", mem[17], 8'h22);
        checkOutput("midrst_mem18", mem[18], 8'h00);
        applyStimulus(8'd2, 8'd50, 7'd2);
        waitDone(cyc);
        checkOutput("midrst_restart_cycles", cyc, 5);
        checkOutput("midrst_restart_mem50", mem[50], 8'h33);
        checkOutput("midrst_restart_mem51", mem[51], 8'h44);

        // Wrap-around: the read of address 0 sees the byte just written there.
        preload(62, 8'hA1); preload(63, 8'hA2); preload(0, 8'hA3); preload(1, 8'hA4);
        applyStimulus(8'd62, 8'd0, 7'd4);
        waitDone(cyc);
        checkOutput("wrap_cycles", cyc, 9);
        checkOutput("wrap_mem0", mem[0], 8'hA1);
        checkOutput("wrap_mem1", mem[1], 8'hA2);
        checkOutput("wrap_mem2", mem[2], 8'hA1);
        checkOutput("wrap_mem3", mem[3], 8'hA2);

        // Forward overlap replicates the first byte.
        preload(0, 8'h5A);
        for (int i = 1; i < 10; i++) preload(i, 8'(i));
        applyStimulus(8'd0, 8'd1, 7'd8);
        waitDone(cyc);
        checkOutput("overlap_cycles", cyc, 17);
        for (int i = 1; i <= 8; i++) checkOutput($sformatf("overlap_mem%0d", i), mem[i], 8'h5A);
        checkOutput("overlap_mem9", mem[9], 8'h09);

        // Zero length: done in the next cycle, no memory access.
        wBefore = writeCount;
        applyStimulus(8'd5, 8'd9, 7'd0);
        waitDone(cyc);
        checkOutput("zero_cycles", cyc, 1);
        checkOutput("zero_busy", firstBusy, 0);
        checkOutput("zero_writes", writeCount - wBefore, 0);
        checkOutput("zero_bytes_done", bytes_done, 0);

        // Oversize length clamps to the full 64-byte space.
        wBefore = writeCount;
        applyStimulus(8'd0, 8'd0, 7'd100);
        waitDone(cyc);
        checkOutput("clamp_cycles", cyc, 129);
        checkOutput("clamp_writes", writeCount - wBefore, 64);
        checkOutput("clamp_bytes_done", bytes_done, 64);

`ifdef MEMCPY_FILL_EN
        // Fill mode writes a constant every cycle with no READ phase.
        for (int i = 32; i < 38; i++) preload(i, 8'h00);
        fill_en  = 1'b1;
        fill_val = 8'hFF;
        wBefore  = writeCount;
        applyStimulus(8'd7, 8'd32, 7'd5);
        fill_en  = 1'b0;
        waitDone(cyc);
        checkOutput("fill_cycles", cyc, 6);
        checkOutput("fill_first_write", firstWrite, 1);
        checkOutput("fill_first_addr", firstAddr, 32);
        checkOutput("fill_writes", writeCount - wBefore, 5);
        for (int i = 32; i < 37; i++) checkOutput($sformatf("fill_mem%0d", i), mem[i], 8'hFF);
        checkOutput("fill_mem37", mem[37], 8'h00);
`endif

        checkOutput("addr_upper_zero", addrHiCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Memory-side initiator that drives the single-port 8-bit data memory's write/address/data inputs and consumes its combinational read data. On a start request it copies a block of bytes from a source to a destination region of the 64-byte data space, one byte at a time. While it runs, the engine owns the memory port. Processor-side muxing is done outside this block, using `busy`.

## Interface
Parameters:
- `ADDR_W`, default 6: implemented address bits; memory depth is 2^ADDR_W.
- `LEN_W`, default 7: width of the length operand; must hold 2^ADDR_W.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `src` in 8: source base address.
- `dst` in 8: destination base address.
- `len` in LEN_W: byte count.
- `busy` out 1: high while the engine owns the memory port.
- `done` out 1: one-cycle completion pulse.
- `bytes_done` out LEN_W: bytes written so far in the current or last transfer.
- `mem_addr` out 8: address to memory; upper 8-ADDR_W bits are always 0.
- `mem_wdata` out 8: write data to memory.
- `mem_write` out 1: memory write enable.
- `mem_rdata` in 8: combinational read data from memory.

## Operation
- States: IDLE, READ, WRITE, FINISH.
- **IDLE**
  - On `start`=1, latch `src`, `dst` and `len`, and clear the byte index and `bytes_done`.
  - If `len`=0, go to FINISH; otherwise go to READ.
  - `start` in any other state is ignored and is not queued.
- **Length clamp:** `len` greater than 2^ADDR_W is clamped to 2^ADDR_W.
- **READ**
  - `mem_addr` = (src+i) mod 2^ADDR_W, `mem_write`=0.
  - Capture `mem_rdata` into the byte buffer at the clock edge, then go to WRITE.
- **WRITE**
  - `mem_addr` = (dst+i) mod 2^ADDR_W, `mem_wdata` = buffer, `mem_write`=1.
  - At the edge, i and `bytes_done` increment.
  - If i+1 equals the length, go to FINISH; otherwise go to READ.
- **FINISH:** `done`=1 for exactly one cycle, `busy`=0, then go to IDLE.
- **Address arithmetic:** addresses wrap modulo 2^ADDR_W, so a region running past 63 continues at 0.
- **Overlapping regions:** the copy is strictly forward, ascending i.
  - If dst > src and the regions overlap, source bytes are overwritten before they are read, and the pattern replicates.
  - This is the defined behaviour, not an error.
- **Idle outputs:** `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.

## Timing
- **Reset values:** `busy`=0, `done`=0, `bytes_done`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, state IDLE.
- **Reset mid-transfer:** takes effect immediately and asynchronously. `mem_write` drops the same instant, and the partial transfer is abandoned without a `done` pulse.
- **Cycle sequence** (start sampled at edge k):
  - READ occupies cycle k+1.
  - Each byte takes 2 cycles, READ then WRITE.
  - The last WRITE is in cycle k+2·len.
  - The `done` pulse is in cycle k+2·len+1.
- **Zero length:** `len`=0 gives the `done` pulse in cycle k+1 with no memory access.
- **busy:** high in READ and WRITE states only.
- **Outputs are registered/state-decoded:** `mem_addr`, `mem_wdata` and `mem_write` must not depend combinationally on `start`.
- **Back-to-back:** a `start` in the same cycle as the `done` pulse is ignored. The next request is accepted one cycle after `done`.

## Configuration
- **`MEMCPY_FILL_EN` defined:**
  - Adds ports `fill_en` in 1 and `fill_val` in 8, both latched at start.
  - With `fill_en`=1 the engine skips READ. Each WRITE stores `fill_val` at (dst+i).
  - This is 1 cycle per byte: `done` in cycle k+len+1.
  - `src` is ignored.
- **`MEMCPY_FILL_EN` undefined:** those ports are absent and the engine is copy-only.

## Structure
- **Shared package `mem_copy_pkg`:**
  - State enum (IDLE, READ, WRITE, FINISH).
  - Default ADDR_W / LEN_W constants.
  - Memory data width constant (8).
- **No sub-module.** The counter, address adders and FSM stay in one module. The memory instance and the processor/engine port mux belong to the integrating top level.

## Test plan
- **Basic copy:** preload mem[0..3]=11,22,33,44; start src=0, dst=16, len=4.
  - Expect mem[16..19]=11,22,33,44, `done` in cycle k+9, `bytes_done`=4.
  - src bytes unchanged.
- **Wrap-around:** src=62, dst=0, len=4 with mem[62,63,0,1]=A1,A2,A3,A4.
  - Expect the read from mem[0] to return A1 already written, so the result is mem[0..3]=A1,A2,A1,A2.
- **Zero length and clamp:**
  - `len`=0 gives `done` at k+1 and no `mem_write` ever high.
  - `len`=100 gives exactly 64 writes and `bytes_done`=64.
- **Overlap forward:** mem[0]=5A; src=0, dst=1, len=8. Expect mem[1..8] all 5A.
- **Reset mid-transfer:** assert `rst_n`=0 during the 3rd WRITE.
  - `mem_write` falls immediately, with no `done` pulse.
  - After release: all outputs are 0 and a new start works normally.
- **Fill mode (`MEMCPY_FILL_EN`):** `fill_en`=1, `fill_val`=FF, dst=32, len=5.
  - Expect mem[32..36]=FF, `done` at k+6, and no READ cycles.
- **Busy start:** `start` while `busy` is ignored.
